// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the default
// baud divisor used by both uart_rx and uart_tx.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // 16 clocks per bit (divisor holds clocks-per-bit minus one).
  localparam int unsigned UART_DEFAULT_DIV = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; data_o always shows the oldest entry.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready output buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rx_i,
  input  logic [DIV_WIDTH-1:0]      baud_div_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      frame_err_o,
  output logic                      overrun_o,
  output logic                      busy_o
);

  // Handshake: a byte moves out on every cycle where valid_o && ready_i;
  // data_o is held while valid_o is high and ready_i is low.

  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  logic rx_meta_q, rx_s_q, rx_q;

  uart_rx_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]       cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]       div_q, div_d;
  logic [BIT_W-1:0]           bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic                       frame_err_q, frame_err_d;
  logic                       overrun_q;
  logic                       push_req;

  logic                       pop;
  logic                       buf_full;
  logic                       buf_empty;
  logic [UART_DATA_BITS-1:0]  buf_head;
  logic                       push_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_q      <= rx_s_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= push_req && buf_full && !pop;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Edge-triggered so a line held low (break) cannot restart a frame.
        if (rx_q && !rx_s_q) begin
          state_d = START;
          div_d   = baud_div_i;
          cnt_d   = baud_div_i >> 1;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = div_q;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = div_q;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (rx_s_q) push_req    = 1'b1;
          else        frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop     = !buf_empty && ready_i;
  assign push_ok = push_req && (!buf_full || pop);

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_ok),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );
`else
  logic [UART_DATA_BITS-1:0] hold_q;
  logic                      hold_v_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else if (push_ok) begin
      hold_q   <= shift_q;
      hold_v_q <= 1'b1;
    end else if (pop) begin
      hold_v_q <= 1'b0;
    end
  end

  assign buf_head  = hold_q;
  assign buf_full  = hold_v_q;
  assign buf_empty = !hold_v_q;
`endif

  assign valid_o     = !buf_empty;
  assign data_o      = buf_empty ? '0 : buf_head;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames are driven bit by bit, received
// bytes are checked against an expected queue, pulses and latencies are counted.
module tb_uart_rx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        rdy;
  logic [15:0] baud;
  logic [7:0]  data;
  logic        valid, fe, ov, busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_start = 0;

  logic [7:0] exp_q[$];

  int   valid_rise_cyc = -1000;
  int   valid_hi_cnt = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  logic valid_prev = 1'b0;
  logic rdy_prev = 1'b1;
  logic [7:0] data_prev = '0;

  int fe0, ov0, vh0;

`ifdef UART_RX_FIFO_EN
  localparam int OVR_AFTER_2 = 0;
  localparam int OVR_TOTAL   = 1;
  localparam int KEPT        = 4;
`else
  localparam int OVR_AFTER_2 = 1;
  localparam int OVR_TOTAL   = 4;
  localparam int KEPT        = 1;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .baud_div_i  (baud),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (rdy),
    .frame_err_o (fe),
    .overrun_o   (ov),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [9:0] frame, input int nbits, input int bit_clks);
    t_start = cyc;
    for (int i = 0; i < nbits; i++) begin
      rx = frame[i];
      tick(bit_clks);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_clks);
    send_bits({stop_bit, b, 1'b0}, 10, bit_clks);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      valid_prev = 1'b0;
    end else begin
      if (valid) valid_hi_cnt++;
      if (valid && !valid_prev) valid_rise_cyc = cyc;
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
      if (valid && valid_prev && !rdy_prev) chk("hold_stable", 32'(data), 32'(data_prev));
      if (valid && rdy) begin
        if (exp_q.size() == 0) chk("spurious_byte", 32'(valid), 32'd0);
        else                   chk("rx_byte", 32'(data), 32'(exp_q.pop_front()));
      end
      valid_prev = valid;
      data_prev  = data;
      rdy_prev   = rdy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    rx   = 1'b1;
    rdy  = 1'b1;
    baud = 16'(UART_DEFAULT_DIV);
    tick(4);
    chk("reset_outs", 32'({data, valid, fe, ov, busy}), 32'd0);
    rst = 1'b0;
    tick(4);
    chk("idle_after_reset", 32'({valid, busy}), 32'd0);

    // Single byte, latency and one-cycle valid with ready held high.
    fe0 = fe_cnt; ov0 = ov_cnt; vh0 = valid_hi_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 16);
    tick(4);
    chk("a5_latency_window",
        32'((valid_rise_cyc - t_start >= 152) && (valid_rise_cyc - t_start <= 156)), 32'd1);
    chk("a5_valid_cycles", 32'(valid_hi_cnt - vh0), 32'd1);
    chk("a5_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    chk("a5_no_ovr", 32'(ov_cnt - ov0), 32'd0);
    chk("a5_drained", 32'(exp_q.size()), 32'd0);

    // Short low glitch must be rejected at the start-bit midpoint.
    fe0 = fe_cnt; vh0 = valid_hi_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(2);
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    tick(10);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    chk("glitch_no_valid", 32'(valid_hi_cnt - vh0), 32'd0);
    chk("glitch_no_ferr", 32'(fe_cnt - fe0), 32'd0);

    // Bad stop bit followed by a long break.
    fe0 = fe_cnt; vh0 = valid_hi_cnt;
    send_byte(8'h3C, 1'b0, 16);
    tick(40 * 16);
    chk("break_one_ferr", 32'(fe_cnt - fe0), 32'd1);
    chk("break_no_valid", 32'(valid_hi_cnt - vh0), 32'd0);
    chk("break_idle", 32'(busy), 32'd0);
    rx = 1'b1;
    tick(32);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 16);
    tick(4);
    chk("after_break_no_ferr", 32'(fe_cnt - fe0), 32'd1);
    chk("after_break_drained", 32'(exp_q.size()), 32'd0);

    // Overrun with the consumer stalled.
    rdy = 1'b0;
    ov0 = ov_cnt;
    for (int i = 1; i <= KEPT; i++) exp_q.push_back(8'(i));
    send_byte(8'h01, 1'b1, 16);
    send_byte(8'h02, 1'b1, 16);
    tick(2);
    chk("ovr_after_2", 32'(ov_cnt - ov0), 32'(OVR_AFTER_2));
    send_byte(8'h03, 1'b1, 16);
    send_byte(8'h04, 1'b1, 16);
    send_byte(8'h05, 1'b1, 16);
    tick(4);
    chk("ovr_total", 32'(ov_cnt - ov0), 32'(OVR_TOTAL));
    chk("ovr_head", 32'(data), 32'h01);
    chk("ovr_valid", 32'(valid), 32'd1);
    rdy = 1'b1;
    tick(10);
    chk("ovr_drained", 32'(exp_q.size()), 32'd0);
    chk("ovr_empty", 32'(valid), 32'd0);

    // Reset in the middle of data bit 3; the abandoned byte never appears.
    fe0 = fe_cnt; vh0 = valid_hi_cnt;
    send_bits({1'b1, 8'h08, 1'b0}, 4, 16);
    rx = 1'b1;
    tick(8);
    chk("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("midframe_rst_outs", 32'({data, valid, fe, ov, busy}), 32'd0);
    rst = 1'b0;
    tick(32);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, 16);
    tick(4);
    chk("post_rst_one_valid", 32'(valid_hi_cnt - vh0), 32'd1);
    chk("post_rst_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

    // Fastest legal divisor, back-to-back frames.
    baud = 16'd3;
    fe0 = fe_cnt; ov0 = ov_cnt; vh0 = valid_hi_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'hFF, 1'b1, 4);
    tick(20);
    chk("fast_two_valids", 32'(valid_hi_cnt - vh0), 32'd2);
    chk("fast_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    chk("fast_no_ovr", 32'(ov_cnt - ov0), 32'd0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
